nibble_serial_add_ctrl: RTL and testbench
=========================================

# nibble_serial_add_ctrl

Sequencing controller that adds two multi-nibble operands using a single shared 4-bit adder slice, one nibble per clock, least-significant nibble first, with a registered carry between nibbles. It sits between the operand source and the hex-display path: the per-nibble result stream feeds the binary-to-hex decoder directly, and the full sum is presented at completion.

## Interface
- NIBBLES, 4, operand width in nibbles; legal range 2..16; operands are 4*NIBBLES bits
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  4*NIBBLES  operand A, captured on accepted start
- b  input  4*NIBBLES  operand B, captured on accepted start
- sub  input  1  subtract select, captured on accepted start (present only with NIBBLE_SUB_EN)
- busy  output  1  high from the cycle after accept through the DONE cycle
- done  output  1  one-cycle pulse; sum valid
- sum  output  4*NIBBLES+1  result; MSB is final carry-out; held until next accept
- nib_valid  output  1  high while a result nibble is presented
- nib_out  output  4  current result nibble
- nib_idx  output  max(1,$clog2(NIBBLES))  index of nib_out, 0 = LSB nibble

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 -> capture a, b (and sub), clear carry register (set to 1 for subtract), clear nibble counter, clear sum, go RUN. start=0 -> stay.
- RUN: adder slice gets a[nibble i], b[nibble i] (inverted for subtract), carry register; result nibble written into sum[4i+3:4i], carry-out stored. Counter increments; after nibble NIBBLES-1, sum[4*NIBBLES] = final carry-out, go DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- start asserted in RUN or DONE: ignored, not queued; operands not recaptured.
- Arithmetic: sum = a + b (+0), unsigned, 4*NIBBLES+1 bits. Subtract: sum = a + ~b + 1; MSB=1 means a >= b (no borrow); low bits are the two's-complement difference.
- Counter does not wrap: terminates at NIBBLES-1.
- nib_valid/nib_out/nib_idx are registered copies of the nibble just computed.

## Timing
- Accepting edge = cycle 0. Nibble i computed in cycle i+1; nib_valid=1, nib_out, nib_idx=i visible during cycle i+2.
- done=1 and full sum valid in cycle NIBBLES+2 (after the final registered update); latency start->done = NIBBLES+2 cycles.
- Back-to-back: earliest next accept is the cycle after done.
- Reset values: state IDLE, busy 0, done 0, sum 0, nib_valid 0, nib_out 0, nib_idx 0, carry 0.
- rst during RUN/DONE: abort next edge, all outputs to reset values, no done pulse. rst and start together: rst wins.

## Configuration
- NIBBLE_SUB_EN defined: sub port exists; subtract mode as above.
- NIBBLE_SUB_EN undefined: no sub port; carry seeds 0; b never inverted; add only.

## Structure
- Shared package: FSM state enum (IDLE/RUN/DONE), NIBBLE_W = 4 constant.
- One sub-module: nibble_adder_cin, 4-bit ripple adder with carry-in and carry-out built from the existing full-adder cell; the controller instantiates exactly one.

## Test plan
- NIBBLES=4, a=0x1234, b=0x0FFF, add -> nib_out stream 3,3,2,2 at idx 0..3; done with sum=0x02233.
- a=0xFFFF, b=0x0001 -> carry ripples through all nibbles; nib_out 0,0,0,0; sum=0x10000.
- start pulsed again in cycle 2 with a=0xAAAA -> ignored; busy unchanged; original sum delivered; done exactly once.
- rst asserted in cycle 3 of RUN -> next cycle busy=0, sum=0, nib_valid=0; no done pulse; new start afterwards yields correct result.
- NIBBLE_SUB_EN: a=0x0005, b=0x0007, sub=1 -> sum=0x0FFFE (MSB 0, borrow); a=0x0007, b=0x0005 -> sum=0x10002.
- NIBBLES=2, a=0xFF, b=0xFF -> done 4 cycles after accept, sum=0x1FE; nib_idx is 1 bit.

Source files
------------

// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types for the nibble-serial adder controller: FSM states, slice width
// and the full-adder cell the 4-bit slice is built from.
package nibble_serial_add_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_adder.sv
// nibble_adder_cin: 4-bit ripple-carry adder slice with carry-in and carry-out,
// chained from single-bit full-adder cells.
module nibble_adder_cin
    import nibble_serial_add_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    logic [1:0] fa;
    logic       carry;

    always_comb begin
        s     = '0;
        fa    = '0;
        carry = cin;
        for (int k = 0; k < NIBBLE_W; k++) begin
            fa    = full_add(x[k], y[k], carry);
            s[k]  = fa[0];
            carry = fa[1];
        end
        cout = carry;
    end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial add (optionally subtract, NIBBLE_SUB_EN) controller driving a
// single shared 4-bit adder slice, LSB nibble first, with a registered carry.
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = NIBBLE_W * NIBBLES,
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [W-1:0]        a,
    input  logic [W-1:0]        b,
`ifdef NIBBLE_SUB_EN
    input  logic                sub,
`endif
    output logic                busy,
    output logic                done,
    output logic [W:0]          sum,
    output logic                nib_valid,
    output logic [NIBBLE_W-1:0] nib_out,
    output logic [IDX_W-1:0]    nib_idx
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

    state_t              state, state_d;
    logic [W-1:0]        a_q, b_q;
    logic                carry_q;
    logic [IDX_W-1:0]    cnt;
    logic                fin;
    logic                sub_in, sub_q;
    logic [NIBBLE_W-1:0] a_nib, b_nib, b_eff, slice_s;
    logic                slice_c;

`ifdef NIBBLE_SUB_EN
    assign sub_in = sub;

    always_ff @(posedge clk) begin
        if (rst)
            sub_q <= 1'b0;
        else if (state == IDLE && start)
            sub_q <= sub;
    end
`else
    assign sub_in = 1'b0;
    assign sub_q  = 1'b0;
`endif

    assign a_nib = a_q[NIBBLE_W*int'(cnt) +: NIBBLE_W];
    assign b_nib = b_q[NIBBLE_W*int'(cnt) +: NIBBLE_W];
    // Subtract is a + ~b + 1: the +1 comes from the carry seeded at accept.
    assign b_eff = b_nib ^ {NIBBLE_W{sub_q}};

    nibble_adder_cin u_slice (
        .x    (a_nib),
        .y    (b_eff),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_c)
    );

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (fin) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // fin marks the extra RUN cycle that commits the final carry into sum[W].
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            cnt       <= '0;
            fin       <= 1'b0;
            sum       <= '0;
            nib_valid <= 1'b0;
            nib_out   <= '0;
            nib_idx   <= '0;
        end else begin
            state     <= state_d;
            nib_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= sub_in;
                        cnt     <= '0;
                        fin     <= 1'b0;
                        sum     <= '0;
                    end
                end
                RUN: begin
                    if (fin) begin
                        sum[W] <= carry_q;
                        fin    <= 1'b0;
                    end else begin
                        sum[NIBBLE_W*int'(cnt) +: NIBBLE_W] <= slice_s;
                        carry_q   <= slice_c;
                        nib_valid <= 1'b1;
                        nib_out   <= slice_s;
                        nib_idx   <= cnt;
                        if (cnt == LAST)
                            fin <= 1'b1;
                        else
                            cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl (NIBBLES=4 main DUT plus a
// NIBBLES=2 instance); define NIBBLE_SUB_EN to also exercise subtract.
module tb_nibble_serial_add_ctrl;

    localparam int N     = 4;
    localparam int W     = 4 * N;
    localparam int IDX_W = 2;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             start;
    logic [W-1:0]     a, b;
    logic             sub;
    logic             busy, done;
    logic [W:0]       sum;
    logic             nib_valid;
    logic [3:0]       nib_out;
    logic [IDX_W-1:0] nib_idx;

    logic       start2;
    logic [7:0] a2, b2;
    logic       busy2, done2;
    logic [8:0] sum2;
    logic       nib_valid2;
    logic [3:0] nib_out2;
    logic       nib_idx2;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q[$];

    nibble_serial_add_ctrl #(.NIBBLES(N)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
`ifdef NIBBLE_SUB_EN
        .sub       (sub),
`endif
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .nib_valid (nib_valid),
        .nib_out   (nib_out),
        .nib_idx   (nib_idx)
    );

    nibble_serial_add_ctrl #(.NIBBLES(2)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .start     (start2),
        .a         (a2),
        .b         (b2),
`ifdef NIBBLE_SUB_EN
        .sub       (1'b0),
`endif
        .busy      (busy2),
        .done      (done2),
        .sum       (sum2),
        .nib_valid (nib_valid2),
        .nib_out   (nib_out2),
        .nib_idx   (nib_idx2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain wide arithmetic on the whole operands.
    function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
        longint t;
        logic [W-1:0] yn;
        yn = ~y;
        if (s)
            t = longint'(x) + longint'(yn) + 64'd1;
        else
            t = longint'(x) + longint'(y);
        return (W+1)'(t);
    endfunction

    // Driver + per-cycle checker. Called and returns at a negedge.
    // Cycle c = interval after the c-th edge following the accepting edge.
    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs,
                         input bit glitch);
        logic [W:0] r;
        logic [3:0] nib;
        bit         in_stream;
        r = ref_sum(xa, xb, xs);
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back(r[4*i +: 4]);
        a = xa; b = xb; sub = xs; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= N + 3; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                a = W'($urandom);
                b = W'($urandom);
            end
            if (glitch && c == 2) begin
                start = 1'b1;
                a = 16'hAAAA;
            end
            if (glitch && c == 3) start = 1'b0;
            in_stream = (c >= 2 && c <= N + 1);
            check("busy", 32'(busy), 32'(c <= N + 2));
            check("done", 32'(done), 32'(c == N + 2));
            check("nib_valid", 32'(nib_valid), 32'(in_stream));
            if (in_stream && exp_q.size() > 0) begin
                nib = exp_q.pop_front();
                check("nib_out", 32'(nib_out), 32'(nib));
                check("nib_idx", 32'(nib_idx), 32'(c - 2));
            end
            if (c == N + 2) check("sum", 32'(sum), 32'(r));
        end
    endtask

    // Reset lands at the end of cycle 3 together with a start request.
    task automatic abort_op(input logic [W-1:0] xa, input logic [W-1:0] xb);
        a = xa; b = xb; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c <= 3) check("abort_busy_pre", 32'(busy), 32'd1);
            if (c == 3) begin
                rst = 1'b1;
                start = 1'b1;
            end
            if (c == 4) begin
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                check("abort_sum", 32'(sum), 32'd0);
                check("abort_nib_valid", 32'(nib_valid), 32'd0);
                check("abort_nib_out", 32'(nib_out), 32'd0);
                check("abort_nib_idx", 32'(nib_idx), 32'd0);
                rst = 1'b0;
                start = 1'b0;
            end
            if (c >= 5) begin
                check("abort_no_done", 32'(done), 32'd0);
                check("abort_idle", 32'(busy), 32'd0);
            end
        end
    endtask

    initial begin
        int unsigned idle;
        logic        xs;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_nib_valid", 32'(nib_valid), 32'd0);
        check("rst_nib_out", 32'(nib_out), 32'd0);
        check("rst_nib_idx", 32'(nib_idx), 32'd0);
        rst = 1'b0;

        do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        do_op(16'h1234, 16'h0FFF, 1'b0, 1'b1);
        abort_op(16'h4321, 16'h1111);
        do_op(16'h4321, 16'h1111, 1'b0, 1'b0);
`ifdef NIBBLE_SUB_EN
        do_op(16'h0005, 16'h0007, 1'b1, 1'b0);
        do_op(16'h0007, 16'h0005, 1'b1, 1'b0);
`endif

        for (int k = 0; k < 25; k++) begin
            idle = $urandom_range(0, 2);
            repeat (idle) @(negedge clk);
`ifdef NIBBLE_SUB_EN
            xs = 1'($urandom_range(0, 1));
`else
            xs = 1'b0;
`endif
            do_op(W'($urandom), W'($urandom), xs, $urandom_range(0, 3) == 0);
        end

        // NIBBLES=2: 0xFF + 0xFF, nibble stream E, F; done 4 cycles after accept.
        a2 = 8'hFF; b2 = 8'hFF; start2 = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) start2 = 1'b0;
            check("n2_done", 32'(done2), 32'(c == 4));
            check("n2_busy", 32'(busy2), 32'(c <= 4));
            check("n2_nib_valid", 32'(nib_valid2), 32'(c == 2 || c == 3));
            if (c == 2) begin
                check("n2_nib_out0", 32'(nib_out2), 32'hE);
                check("n2_nib_idx0", 32'(nib_idx2), 32'd0);
            end
            if (c == 3) begin
                check("n2_nib_out1", 32'(nib_out2), 32'hF);
                check("n2_nib_idx1", 32'(nib_idx2), 32'd1);
            end
            if (c == 4) check("n2_sum", 32'(sum2), 32'h1FE);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
